// File: rtl/ipf_pkg.sv
// Shared types and size helpers for the IPF LCU scheduler.
package ipf_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } ipf_state_e;

    localparam int IMG_W_LOG2 = 7;
    localparam int LCU_DIM_16 = 16;
    localparam int LCU_DIM_32 = 32;
    localparam int LCU_DIM_64 = 64;

    // Size code 3 is reserved and behaves as 64x64.
    function automatic logic [1:0] eff_size(input logic [1:0] size);
        return (size == 2'd3) ? 2'd2 : size;
    endfunction

    function automatic logic [6:0] lcu_n(input logic [1:0] size);
        case (eff_size(size))
            2'd0:    return 7'(LCU_DIM_16);
            2'd1:    return 7'(LCU_DIM_32);
            default: return 7'(LCU_DIM_64);
        endcase
    endfunction

    function automatic logic [2:0] lcu_max(input logic [1:0] size);
        return 3'd7 >> eff_size(size);
    endfunction

endpackage

// File: rtl/ipf_row_ring_ptr.sv
// Three-slot rotating pointer for the IPF row ring buffer.
module ipf_row_ring_ptr (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_i,
    input  logic       restart_i,
    input  logic       rot_i,
    output logic [1:0] prev_o,
    output logic [1:0] cur_o,
    output logic [1:0] next_o,
    output logic [1:0] load_slot_o
);
    logic [1:0] prev_q, cur_q, next_q;
    logic [1:0] prev_d, cur_d, next_d;

    always_comb begin
        prev_d = prev_q;
        cur_d  = cur_q;
        next_d = next_q;
        if (init_i) begin
            prev_d = 2'd2;
            cur_d  = 2'd0;
            next_d = 2'd1;
        end else if (restart_i) begin
            prev_d = 2'd0;
            cur_d  = 2'd1;
            next_d = 2'd2;
        end else if (rot_i) begin
            prev_d = cur_q;
            cur_d  = next_q;
            next_d = prev_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 2'd0;
            cur_q  <= 2'd0;
            next_q <= 2'd0;
        end else begin
            prev_q <= prev_d;
            cur_q  <= cur_d;
            next_q <= next_d;
        end
    end

    assign prev_o      = prev_q;
    assign cur_o       = cur_q;
    assign next_o      = next_q;
    // Rotation happens on row advance, so the freed slot (old prev) now sits in next.
    assign load_slot_o = next_q;

endmodule

// File: rtl/ipf_lcu_scheduler.sv
// IPF LCU scheduler: paces pixel input, fills the 3-row ring and issues row_start per LCU row.
// Optional stall counter port perf_stall when IPF_SCHED_PERF_EN is defined.
module ipf_lcu_scheduler #(
    parameter int IMG_W_LOG2 = ipf_pkg::IMG_W_LOG2,
    parameter int ADDR_W     = 2 * IMG_W_LOG2,
    parameter int COL_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_en,
    input  logic [2:0]        lcu_x,
    input  logic [2:0]        lcu_y,
    input  logic [1:0]        lcu_size,
    input  logic              core_done,
    output logic              busy,
    output logic              wr_en,
    output logic [1:0]        wr_slot,
    output logic [COL_W-1:0]  wr_col,
    output logic              row_start,
    output logic [COL_W-1:0]  row_idx,
    output logic [1:0]        slot_prev,
    output logic [1:0]        slot_cur,
    output logic [1:0]        slot_next,
    output logic              row_top,
    output logic              row_bot,
    output logic [ADDR_W-1:0] row_base_addr,
    output logic              finish
`ifdef IPF_SCHED_PERF_EN
    ,
    output logic [15:0]       perf_stall
`endif
);
    import ipf_pkg::*;

    localparam int CNT_W = COL_W + 1;

    ipf_state_e        state_q, state_d;
    logic              busy_q, busy_d;
    logic              row_start_q, row_start_d;
    logic              finish_q, finish_d;
    logic              row_top_q, row_top_d;
    logic              row_bot_q, row_bot_d;
    logic [COL_W-1:0]  row_idx_q, row_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_calc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        lcu_x_q, lcu_x_d, lcu_y_q, lcu_y_d;
    logic [1:0]        size_q, size_d;
    logic              upd_row, ring_init, ring_restart, ring_rot;
    logic [1:0]        load_slot;

    logic [CNT_W-1:0]  n;
    logic [COL_W-1:0]  n_m1;
    logic [CNT_W-1:0]  fill_last;
    logic [2:0]        sh;
    logic              accept, done_ok, last_lcu;

    assign n         = lcu_n(size_q);
    assign n_m1      = COL_W'(n - 7'd1);
    assign fill_last = CNT_W'({n, 1'b0} - 8'd1);
    assign sh        = 3'd4 + {1'b0, size_q};
    assign accept    = in_en & ~busy_q;
    assign done_ok   = core_done && (state_q == ST_RUN) && !row_start_q;
    assign last_lcu  = (lcu_x_q == lcu_max(size_q)) && (lcu_y_q == lcu_max(size_q));

    assign wr_en   = accept;
    assign wr_col  = cnt_q[COL_W-1:0] & n_m1;
    assign wr_slot = (state_q == ST_LOAD) ? load_slot : {1'b0, (cnt_q >= n)};

    assign addr_calc = (((ADDR_W'(lcu_y_q) << sh) + ADDR_W'(row_idx_d)) << IMG_W_LOG2)
                     + (ADDR_W'(lcu_x_q) << sh);

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        row_start_d  = 1'b0;
        finish_d     = finish_q;
        row_top_d    = row_top_q;
        row_bot_d    = row_bot_q;
        row_idx_d    = row_idx_q;
        cnt_d        = cnt_q;
        lcu_x_d      = lcu_x_q;
        lcu_y_d      = lcu_y_q;
        size_d       = size_q;
        upd_row      = 1'b0;
        ring_init    = 1'b0;
        ring_restart = 1'b0;
        ring_rot     = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    if (cnt_q == '0) begin
                        lcu_x_d = lcu_x;
                        lcu_y_d = lcu_y;
                        size_d  = eff_size(lcu_size);
                    end
                    if (cnt_q == fill_last) begin
                        state_d     = ST_RUN;
                        busy_d      = 1'b1;
                        row_start_d = 1'b1;
                        cnt_d       = '0;
                        row_idx_d   = '0;
                        row_top_d   = 1'b1;
                        row_bot_d   = 1'b0;
                        upd_row     = 1'b1;
                        ring_init   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (cnt_q[COL_W-1:0] == n_m1) begin
                        state_d     = ST_RUN;
                        busy_d      = 1'b1;
                        row_start_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (done_ok) begin
                    cnt_d = '0;
                    if (row_idx_q == n_m1) begin
                        row_idx_d = '0;
                        row_top_d = 1'b0;
                        row_bot_d = 1'b0;
                        if (last_lcu) begin
                            state_d  = ST_FIN;
                            busy_d   = 1'b1;
                            finish_d = 1'b1;
                        end else begin
                            state_d      = ST_FILL;
                            busy_d       = 1'b0;
                            ring_restart = 1'b1;
                        end
                    end else begin
                        row_idx_d = row_idx_q + 1'b1;
                        row_top_d = 1'b0;
                        row_bot_d = (row_idx_d == n_m1);
                        upd_row   = 1'b1;
                        ring_rot  = 1'b1;
                        // Bottom row has no row below to fetch: start it straight away.
                        if (row_idx_d == n_m1) begin
                            row_start_d = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                busy_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FILL;
            busy_q      <= 1'b0;
            row_start_q <= 1'b0;
            finish_q    <= 1'b0;
            row_top_q   <= 1'b0;
            row_bot_q   <= 1'b0;
            row_idx_q   <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            lcu_x_q     <= '0;
            lcu_y_q     <= '0;
            size_q      <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            row_start_q <= row_start_d;
            finish_q    <= finish_d;
            row_top_q   <= row_top_d;
            row_bot_q   <= row_bot_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            lcu_x_q     <= lcu_x_d;
            lcu_y_q     <= lcu_y_d;
            size_q      <= size_d;
            if (upd_row) addr_q <= addr_calc;
        end
    end

    ipf_row_ring_ptr u_ring (
        .clk         (clk),
        .reset       (reset),
        .init_i      (ring_init),
        .restart_i   (ring_restart),
        .rot_i       (ring_rot),
        .prev_o      (slot_prev),
        .cur_o       (slot_cur),
        .next_o      (slot_next),
        .load_slot_o (load_slot)
    );

`ifdef IPF_SCHED_PERF_EN
    logic [15:0] perf_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= 16'd0;
        end else if ((state_q == ST_RUN) && busy_q && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end
    assign perf_stall = perf_q;
`endif

    assign busy          = busy_q;
    assign row_start     = row_start_q;
    assign finish        = finish_q;
    assign row_top       = row_top_q;
    assign row_bot       = row_bot_q;
    assign row_idx       = row_idx_q;
    assign row_base_addr = addr_q;

endmodule

// File: tb/tb_ipf_lcu_scheduler.sv
// Directed bench for ipf_lcu_scheduler with hand-computed expectations.
module tb_ipf_lcu_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_en;
    logic [2:0]  lcu_x, lcu_y;
    logic [1:0]  lcu_size;
    logic        core_done;
    logic        busy, wr_en, row_start, row_top, row_bot, finish;
    logic [1:0]  wr_slot, slot_prev, slot_cur, slot_next;
    logic [5:0]  wr_col, row_idx;
    logic [13:0] row_base_addr;
`ifdef IPF_SCHED_PERF_EN
    logic [15:0] perf_stall;
`endif

    int tests = 0;
    int fails = 0;
    int loads = 0;
    logic [1:0] slot_log [0:127];
    logic [5:0] col_log  [0:127];

    always #5 clk = ~clk;

    ipf_lcu_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .in_en         (in_en),
        .lcu_x         (lcu_x),
        .lcu_y         (lcu_y),
        .lcu_size      (lcu_size),
        .core_done     (core_done),
        .busy          (busy),
        .wr_en         (wr_en),
        .wr_slot       (wr_slot),
        .wr_col        (wr_col),
        .row_start     (row_start),
        .row_idx       (row_idx),
        .slot_prev     (slot_prev),
        .slot_cur      (slot_cur),
        .slot_next     (slot_next),
        .row_top       (row_top),
        .row_bot       (row_bot),
        .row_base_addr (row_base_addr),
        .finish        (finish)
`ifdef IPF_SCHED_PERF_EN
        ,
        .perf_stall    (perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts and ends one time unit after a rising edge.
    task automatic send_pixels(input int n, input bit gap);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < 2000) begin
            in_en = gap ? cyc[0] : 1'b1;
            #1;
            if (wr_en) begin
                slot_log[acc] = wr_slot;
                col_log[acc]  = wr_col;
                acc++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_en = 1'b0;
        chk("pix_count", acc, n);
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        @(posedge clk);
        #1;
        core_done = 1'b0;
    endtask

    task automatic advance_row(input int n);
        @(posedge clk);
        #1;
        pulse_done();
        if (busy == 1'b0) begin
            loads++;
            send_pixels(n, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; in_en = 1'b0; core_done = 1'b0;
        lcu_x = 3'd0; lcu_y = 3'd0; lcu_size = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_finish", finish, 0);
        chk("rst_row_start", row_start, 0);
        chk("rst_slots", {slot_prev, slot_cur, slot_next}, 0);
        chk("rst_row_top", row_top, 0);
        chk("rst_addr", row_base_addr, 0);
        chk("rst_wr_en", wr_en, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] step 1: size2 lcu(0,0) fill");
        lcu_size = 2'd2; lcu_x = 3'd0; lcu_y = 3'd0;
        send_pixels(128, 1'b0);
        chk("fill_slot0", slot_log[0], 0);
        chk("fill_col0", col_log[0], 0);
        chk("fill_slot63", slot_log[63], 0);
        chk("fill_col63", col_log[63], 63);
        chk("fill_slot64", slot_log[64], 1);
        chk("fill_col64", col_log[64], 0);
        chk("fill_col127", col_log[127], 63);
        chk("t1_busy", busy, 1);
        chk("t1_row_start", row_start, 1);
        chk("t1_row_idx", row_idx, 0);
        chk("t1_slot_prev", slot_prev, 2);
        chk("t1_slot_cur", slot_cur, 0);
        chk("t1_slot_next", slot_next, 1);
        chk("t1_row_top", row_top, 1);
        chk("t1_row_bot", row_bot, 0);
        chk("t1_addr", row_base_addr, 0);

        $display("[TB] step 5: in_en while busy, core_done with row_start");
        in_en = 1'b1; core_done = 1'b1;
        #1;
        chk("t5_wr_en_busy", wr_en, 0);
        @(posedge clk);
        #1;
        core_done = 1'b0;
        chk("t5_row_start_drop", row_start, 0);
        chk("t5_done_ignored_busy", busy, 1);
        chk("t5_done_ignored_row", row_idx, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t5_wr_en_hold", wr_en, 0);
        end
        in_en = 1'b0;
        pulse_done();
        chk("t5_load_busy", busy, 0);
        chk("t5_load_row", row_idx, 1);
        chk("t5_load_slots", {slot_prev, slot_cur, slot_next}, {2'd0, 2'd1, 2'd2});
        chk("t5_load_row_top", row_top, 0);
        send_pixels(64, 1'b0);
        chk("t5_load_slot", slot_log[0], 2);
        chk("t5_load_col0", col_log[0], 0);
        chk("t5_load_col63", col_log[63], 63);
        chk("t5_run1_busy", busy, 1);
        chk("t5_run1_start", row_start, 1);
        chk("t5_run1_addr", row_base_addr, 128);

        $display("[TB] step 6: reset mid-LOAD");
        @(posedge clk);
        #1;
        pulse_done();
        send_pixels(10, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_finish", finish, 0);
        chk("t6_row_idx", row_idx, 0);
        chk("t6_slots", {slot_prev, slot_cur, slot_next}, 0);
        chk("t6_addr", row_base_addr, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] step 4: size1 lcu(2,1) full LCU");
        lcu_size = 2'd1; lcu_x = 3'd2; lcu_y = 3'd1;
        send_pixels(64, 1'b0);
        chk("t4_fill_slot31", slot_log[31], 0);
        chk("t4_fill_col31", col_log[31], 31);
        chk("t4_fill_slot32", slot_log[32], 1);
        chk("t4_fill_col32", col_log[32], 0);
        chk("t4_row0_addr", row_base_addr, 4160);
        chk("t4_row0_start", row_start, 1);
        loads = 0;
        for (int r = 0; r < 5; r++) advance_row(32);
        chk("t4_row5_idx", row_idx, 5);
        chk("t4_row5_addr", row_base_addr, 4800);
        chk("t4_row5_slots", {slot_prev, slot_cur, slot_next}, {2'd1, 2'd2, 2'd0});
        for (int r = 5; r < 31; r++) advance_row(32);
        chk("t4_loads", loads, 30);
        chk("t4_row31_idx", row_idx, 31);
        chk("t4_row31_bot", row_bot, 1);
        chk("t4_row31_start", row_start, 1);
        @(posedge clk);
        #1;
        pulse_done();
        chk("t4_end_busy", busy, 0);
        chk("t4_end_finish", finish, 0);

        $display("[TB] step 2/3: size0 lcu(7,7) with gaps");
        lcu_size = 2'd0; lcu_x = 3'd7; lcu_y = 3'd7;
        send_pixels(32, 1'b1);
        chk("t2_fill_col15", col_log[15], 15);
        chk("t2_fill_slot16", slot_log[16], 1);
        chk("t2_row0_addr", row_base_addr, 14448);
        loads = 0;
        for (int r = 0; r < 15; r++) advance_row(16);
        chk("t2_loads", loads, 14);
        chk("t2_row15_idx", row_idx, 15);
        chk("t2_row15_bot", row_bot, 1);
        chk("t2_row15_start", row_start, 1);
        chk("t2_row15_busy", busy, 1);
        chk("t2_row15_addr", row_base_addr, 16368);
        @(posedge clk);
        #1;
        pulse_done();
        chk("t3_finish", finish, 1);
        chk("t3_busy", busy, 1);
        in_en = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("t3_fin_wr_en", wr_en, 0);
        end
        in_en = 1'b0;
        chk("t3_finish_sticky", finish, 1);

        $display("[TB] step 3b: size1 lcu(3,3)");
        reset = 1'b1;
        #1;
        chk("t3b_rst_finish", finish, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        lcu_size = 2'd1; lcu_x = 3'd3; lcu_y = 3'd3;
        send_pixels(64, 1'b0);
        for (int r = 0; r < 31; r++) advance_row(32);
        chk("t3b_row31_addr", row_base_addr, 16352);
        chk("t3b_pre_finish", finish, 0);
        @(posedge clk);
        #1;
        pulse_done();
        chk("t3b_finish", finish, 1);
        chk("t3b_busy", busy, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
